// File: rtl/w_pattern_gen.sv
// ---------------------------------------------------------------------------
// w_pattern_gen
//
// Serial stimulus generator for the `w` input of the two-in-a-row sequence
// detectors. A captured pattern is shifted out MSB first, one bit per clock,
// repeated `reps` times with no gap between passes. A shadow model of the
// detector (z = 1 after two consecutive equal samples of `w`) runs alongside
// and drives the expected Moore output `z_exp`.
//
// Parameters
//   WIDTH   pattern length in bits (>= 2)
//   REPS_W  width of the repeat-count input
//
// Ports
//   clk      in   rising-edge clock, one `w` bit per edge
//   reset    in   synchronous, active-high reset
//   start    in   begin a run; sampled only while idle
//   pattern  in   bits to emit, pattern[WIDTH-1] first
//   reps     in   number of passes (0 behaves as 1)
//   w        out  serial stimulus bit
//   busy     out  high while bits are being emitted
//   done     out  one-cycle pulse after the final bit
//   z_exp    out  expected Moore z of the two-in-a-row detector
//   bit_idx  out  index of the bit currently on `w` (0 = MSB position)
// ---------------------------------------------------------------------------
module w_pattern_gen #(
    parameter int WIDTH  = 8,
    parameter int REPS_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [REPS_W-1:0]        reps,
    output logic                     w,
    output logic                     busy,
    output logic                     done,
    output logic                     z_exp,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [REPS_W-1:0]  passes_q, passes_d;   // passes left, including the current one
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               w_q, w_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               z_exp_q, z_exp_d;
    logic               w_prev_q, w_prev_d;
    logic               have_prev_q, have_prev_d;

    // NOTE: every register, including the captured pattern, is reset so a
    // mid-run reset leaves no stale run state behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            passes_q    <= '0;
            idx_q       <= '0;
            w_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            z_exp_q     <= 1'b0;
            w_prev_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            pat_q       <= pat_d;
            passes_q    <= passes_d;
            idx_q       <= idx_d;
            w_q         <= w_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            z_exp_q     <= z_exp_d;
            w_prev_q    <= w_prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        pat_d       = pat_q;
        passes_d    = passes_q;
        idx_d       = idx_q;
        w_d         = w_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        have_prev_d = have_prev_q;

        // Shadow detector: tracks the held `w` in IDLE as well, because the
        // real detectors keep sampling it.
        z_exp_d  = have_prev_q & (w_q == w_prev_q);
        w_prev_d = w_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SHIFT;
                    pat_d       = pattern;
                    passes_d    = (reps == '0) ? REPS_W'(1) : reps;
                    idx_d       = '0;
                    w_d         = pattern[WIDTH-1];
                    busy_d      = 1'b1;
                    have_prev_d = 1'b0;
                end
            end

            SHIFT: begin
                have_prev_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    if (passes_q == REPS_W'(1)) begin
                        // Last bit of last pass: `w` holds its value.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        passes_d = passes_q - REPS_W'(1);
                        idx_d    = '0;
                        w_d      = pat_q[WIDTH-1];
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    // bit_idx counts from the MSB, so invert it to index pat_q.
                    w_d   = pat_q[LAST_IDX - (idx_q + IDX_W'(1))];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign w       = w_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign z_exp   = z_exp_q;
    assign bit_idx = idx_q;

endmodule

// File: tb/tb_w_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_w_pattern_gen
//
// Directed bench for w_pattern_gen (WIDTH=8, REPS_W=4). Cycle c is the clock
// period that follows edge c-1, with edge 0 being the edge that accepts
// `start`. Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_w_pattern_gen;

    localparam int WIDTH  = 8;
    localparam int REPS_W = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  pattern;
    logic [REPS_W-1:0] reps;
    logic              w;
    logic              busy;
    logic              done;
    logic              z_exp;
    logic [2:0]        bit_idx;

    int total;
    int bad;

    w_pattern_gen #(
        .WIDTH  (WIDTH),
        .REPS_W (REPS_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .w       (w),
        .busy    (busy),
        .done    (done),
        .z_exp   (z_exp),
        .bit_idx (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] wa;
        logic [7:0] wc;
        logic [7:0] wd;
        logic [7:0] we;
        logic [7:0] wf;
        bit         za [2:10];
        bit         zd [2:9];

        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        reps    = '0;

        // ---------------- reset and idle ----------------
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("idle.w c%0d", c), 32'(w), 32'd0);
            check($sformatf("idle.busy c%0d", c), 32'(busy), 32'd0);
            check($sformatf("idle.done c%0d", c), 32'(done), 32'd0);
            check($sformatf("idle.z c%0d", c), 32'(z_exp), 32'd0);
            check($sformatf("idle.idx c%0d", c), 32'(bit_idx), 32'd0);
        end

        // ---------------- run A: 11001010, reps=1 ----------------
        wa = 8'b1100_1010;
        za = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
        pattern = wa;
        reps    = 4'd1;
        start   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8) begin
                check($sformatf("A.w c%0d", c), 32'(w), 32'(wa[8-c]));
                check($sformatf("A.idx c%0d", c), 32'(bit_idx), 32'(c - 1));
            end else begin
                check($sformatf("A.w_hold c%0d", c), 32'(w), 32'd0);
            end
            if (c >= 2)
                check($sformatf("A.z c%0d", c), 32'(z_exp), 32'(za[c]));
            check($sformatf("A.busy c%0d", c), 32'(busy), 32'(c <= 8));
            check($sformatf("A.done c%0d", c), 32'(done), 32'(c == 9));
        end

        // ---------------- run B: FF, reps=2 ----------------
        pattern = 8'hFF;
        reps    = 4'd2;
        start   = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("B.w c%0d", c), 32'(w), 32'd1);
            if (c <= 16)
                check($sformatf("B.idx c%0d", c), 32'(bit_idx), 32'((c - 1) % 8));
            if (c >= 2)
                check($sformatf("B.z c%0d", c), 32'(z_exp), 32'(c >= 3));
            check($sformatf("B.busy c%0d", c), 32'(busy), 32'(c <= 16));
            check($sformatf("B.done c%0d", c), 32'(done), 32'(c == 17));
        end

        // ---------------- run C: AA, reps=0 (one pass) ----------------
        wc = 8'hAA;
        pattern = wc;
        reps    = 4'd0;
        start   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8)
                check($sformatf("C.w c%0d", c), 32'(w), 32'(wc[8-c]));
            if (c >= 2 && c <= 9)
                check($sformatf("C.z c%0d", c), 32'(z_exp), 32'd0);
            check($sformatf("C.busy c%0d", c), 32'(busy), 32'(c <= 8));
            check($sformatf("C.done c%0d", c), 32'(done), 32'(c == 9));
        end

        // ---------------- run D: 10011100, restart/pattern change ignored ----
        wd = 8'b1001_1100;
        zd = '{0, 0, 1, 0, 1, 1, 0, 1};
        pattern = wd;
        reps    = 4'd1;
        start   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c == 4) begin
                start   = 1'b1;
                pattern = 8'h00;
                reps    = 4'd5;
            end
            if (c <= 8)
                check($sformatf("D.w c%0d", c), 32'(w), 32'(wd[8-c]));
            if (c >= 2 && c <= 9)
                check($sformatf("D.z c%0d", c), 32'(z_exp), 32'(zd[c]));
            check($sformatf("D.busy c%0d", c), 32'(busy), 32'(c <= 8));
            check($sformatf("D.done c%0d", c), 32'(done), 32'(c == 9));
        end

        // ---------------- run E: CA, reps=3, reset in cycle 5 ----------------
        we = 8'b1100_1010;
        pattern = we;
        reps    = 4'd3;
        start   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("E.w c%0d", c), 32'(w), 32'(we[8-c]));
            check($sformatf("E.busy c%0d", c), 32'(busy), 32'd1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("E.rst.busy", 32'(busy), 32'd0);
        check("E.rst.w", 32'(w), 32'd0);
        check("E.rst.z", 32'(z_exp), 32'd0);
        check("E.rst.idx", 32'(bit_idx), 32'd0);
        check("E.rst.done", 32'(done), 32'd0);
        for (int c = 7; c <= 30; c++) begin
            tick();
            check($sformatf("E.post.done c%0d", c), 32'(done), 32'd0);
            check($sformatf("E.post.busy c%0d", c), 32'(busy), 32'd0);
        end

        // ---------------- run F: 0F, reps=1, after reset ----------------
        wf = 8'h0F;
        pattern = wf;
        reps    = 4'd1;
        start   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8)
                check($sformatf("F.w c%0d", c), 32'(w), 32'(wf[8-c]));
            check($sformatf("F.busy c%0d", c), 32'(busy), 32'(c <= 8));
            check($sformatf("F.done c%0d", c), 32'(done), 32'(c == 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
